// File: rtl/mem_access_unit.sv
// Memory-stage load/store unit: turns one M-stage load/store into a single
// valid/ready bus access, stalls the pipeline meanwhile and returns extended load data.
module mem_access_unit #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemReadM,
    input  logic        MemWriteM,
    input  logic [2:0]  Funct3M,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] WriteDataM,
    output logic [31:0] ReadDataM,
    output logic        StallM,
    output logic        MisalignM,
    output logic        BusErrM,
    output logic        bus_req_valid,
    input  logic        bus_req_ready,
    output logic        bus_req_we,
    output logic [31:0] bus_req_addr,
    output logic [31:0] bus_req_wdata,
    output logic [3:0]  bus_req_be,
    input  logic        bus_rsp_valid,
    input  logic [31:0] bus_rsp_rdata
);

    typedef enum logic [1:0] {IDLE, REQ, RSP, DONE} state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             req_we_q, req_we_d;
    logic [31:0]      req_addr_q, req_addr_d;
    logic [31:0]      req_wdata_q, req_wdata_d;
    logic [3:0]       req_be_q, req_be_d;
    logic [31:0]      read_data_q, read_data_d;
    logic             misalign_q, misalign_d;
    logic             bus_err_q, bus_err_d;
    logic [2:0]       funct3_q, funct3_d;
    logic [1:0]       lane_q, lane_d;

    logic             access;
    logic             is_write;
    logic [1:0]       lane;
    logic             misaligned;
    logic [3:0]       store_be;
    logic [31:0]      store_wdata;
    logic [7:0]       load_byte;
    logic [15:0]      load_half;
    logic [31:0]      load_data;

    // Funct3M[1:0] selects the size; codes 10 and 11 both behave as a word.
    always_comb begin
        access      = MemReadM | MemWriteM;
        is_write    = MemWriteM & ~MemReadM;
        lane        = ALUResultM[1:0];
        misaligned  = 1'b0;
        store_be    = 4'b1111;
        store_wdata = WriteDataM;
        case (Funct3M[1:0])
            2'b00: begin
                store_be    = 4'b0001 << lane;
                store_wdata = {4{WriteDataM[7:0]}};
            end
            2'b01: begin
                misaligned  = lane[0];
                store_be    = lane[1] ? 4'b1100 : 4'b0011;
                store_wdata = {2{WriteDataM[15:0]}};
            end
            default: misaligned = (lane != 2'b00);
        endcase
    end

    // Lane and sign info come from the latched request, not the live M-stage inputs.
    always_comb begin
        load_byte = bus_rsp_rdata[7:0];
        case (lane_q)
            2'b01:   load_byte = bus_rsp_rdata[15:8];
            2'b10:   load_byte = bus_rsp_rdata[23:16];
            2'b11:   load_byte = bus_rsp_rdata[31:24];
            default: load_byte = bus_rsp_rdata[7:0];
        endcase
        load_half = lane_q[1] ? bus_rsp_rdata[31:16] : bus_rsp_rdata[15:0];
        case (funct3_q[1:0])
            2'b00:   load_data = {{24{load_byte[7] & ~funct3_q[2]}}, load_byte};
            2'b01:   load_data = {{16{load_half[15] & ~funct3_q[2]}}, load_half};
            default: load_data = bus_rsp_rdata;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        req_we_d    = req_we_q;
        req_addr_d  = req_addr_q;
        req_wdata_d = req_wdata_q;
        req_be_d    = req_be_q;
        read_data_d = read_data_q;
        misalign_d  = 1'b0;
        bus_err_d   = 1'b0;
        funct3_d    = funct3_q;
        lane_d      = lane_q;
        case (state_q)
            IDLE: begin
                if (access && misaligned) begin
                    misalign_d  = 1'b1;
                    read_data_d = 32'h0;
                    state_d     = DONE;
                end else if (access) begin
                    req_we_d    = is_write;
                    req_addr_d  = {ALUResultM[31:2], 2'b00};
                    req_wdata_d = store_wdata;
                    req_be_d    = store_be;
                    funct3_d    = Funct3M;
                    lane_d      = lane;
                    cnt_d       = '0;
                    state_d     = REQ;
                end
            end
            REQ: begin
                if (bus_req_ready) begin
                    cnt_d   = '0;
                    state_d = req_we_q ? DONE : RSP;
                end else if (cnt_q == CNT_LAST) begin
                    bus_err_d   = 1'b1;
                    read_data_d = 32'h0;
                    state_d     = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RSP: begin
                if (bus_rsp_valid) begin
                    read_data_d = load_data;
                    state_d     = DONE;
                end else if (cnt_q == CNT_LAST) begin
                    bus_err_d   = 1'b1;
                    read_data_d = 32'h0;
                    state_d     = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            req_we_q    <= 1'b0;
            req_addr_q  <= 32'h0;
            req_wdata_q <= 32'h0;
            req_be_q    <= 4'h0;
            read_data_q <= 32'h0;
            misalign_q  <= 1'b0;
            bus_err_q   <= 1'b0;
            funct3_q    <= 3'h0;
            lane_q      <= 2'h0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            req_we_q    <= req_we_d;
            req_addr_q  <= req_addr_d;
            req_wdata_q <= req_wdata_d;
            req_be_q    <= req_be_d;
            read_data_q <= read_data_d;
            misalign_q  <= misalign_d;
            bus_err_q   <= bus_err_d;
            funct3_q    <= funct3_d;
            lane_q      <= lane_d;
        end
    end

    // Gating with reset keeps the pipeline free while reset is held with an access pending.
    assign StallM        = reset & (state_q != DONE) & ((state_q != IDLE) | access);
    assign bus_req_valid = (state_q == REQ);
    assign bus_req_we    = req_we_q;
    assign bus_req_addr  = req_addr_q;
    assign bus_req_wdata = req_wdata_q;
    assign bus_req_be    = req_be_q;
    assign ReadDataM     = read_data_q;
    assign MisalignM     = misalign_q;
    assign BusErrM       = bus_err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: a table of directed load/store
// vectors plus hand-written reset sequences, built with TIMEOUT=4.
module tb_mem_access_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        MemReadM, MemWriteM;
   logic [2:0]  Funct3M;
   logic [31:0] ALUResultM, WriteDataM;
   logic [31:0] ReadDataM;
   logic        StallM, MisalignM, BusErrM;
   logic        bus_req_valid, bus_req_ready, bus_req_we;
   logic [31:0] bus_req_addr, bus_req_wdata;
   logic [3:0]  bus_req_be;
   logic        bus_rsp_valid;
   logic [31:0] bus_rsp_rdata;

   int nCompared = 0;
   int nMismatched = 0;

   mem_access_unit #(.TIMEOUT(4), .CNT_W(8)) dut (
      .clk(clk), .reset(reset),
      .MemReadM(MemReadM), .MemWriteM(MemWriteM), .Funct3M(Funct3M),
      .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
      .ReadDataM(ReadDataM), .StallM(StallM), .MisalignM(MisalignM), .BusErrM(BusErrM),
      .bus_req_valid(bus_req_valid), .bus_req_ready(bus_req_ready), .bus_req_we(bus_req_we),
      .bus_req_addr(bus_req_addr), .bus_req_wdata(bus_req_wdata), .bus_req_be(bus_req_be),
      .bus_rsp_valid(bus_rsp_valid), .bus_rsp_rdata(bus_rsp_rdata)
   );

   // 10 ns clock; rising edges at 5, 15, 25, ...
   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic        rd;
      logic        wr;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      int          rdyDly;
      int          rspDly;
      bit          hsRsp;
      int          expStall;
      bit          expReq;
      bit          chkBe;
      logic [3:0]  expBe;
      logic [31:0] expWdata;
      logic [31:0] expRdata;
      bit          expMis;
      bit          expErr;
   } vec_t;

   // Observations filled in by applyStimulus for the caller to check.
   int          obsStall;
   bit          obsReq, obsUnstable, obsDone;
   logic        obsWe;
   logic [31:0] obsAddr, obsWdata, obsRdata;
   logic [3:0]  obsBe;
   logic        obsMis, obsErr, obsValidAtDone, obsMisAfter, obsErrAfter;

   function automatic vec_t mk(string name, logic rd, logic wr, logic [2:0] f3,
                               logic [31:0] addr, logic [31:0] wdata, logic [31:0] rdata,
                               int rdyDly, int rspDly, bit hsRsp, int expStall, bit expReq,
                               bit chkBe, logic [3:0] expBe, logic [31:0] expWdata,
                               logic [31:0] expRdata, bit expMis, bit expErr);
      vec_t v;
      v.name = name; v.rd = rd; v.wr = wr; v.f3 = f3; v.addr = addr; v.wdata = wdata;
      v.rdata = rdata; v.rdyDly = rdyDly; v.rspDly = rspDly; v.hsRsp = hsRsp;
      v.expStall = expStall; v.expReq = expReq; v.chkBe = chkBe; v.expBe = expBe;
      v.expWdata = expWdata; v.expRdata = expRdata; v.expMis = expMis; v.expErr = expErr;
      return v;
   endfunction

   // Every comparison in the bench funnels through here.
   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      nCompared++;
      if (actual !== expected) begin
         nMismatched++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
      end
   endtask

   // Plays one M-stage access starting just after a rising edge with the unit idle;
   // acts as the bus slave and returns one edge after the DONE cycle.
   task automatic applyStimulus(input vec_t v);
      int reqSeen = 0;
      int rspSeen = 0;
      bit inRsp = 0;
      bit inRspNext = 0;
      obsStall = 0; obsReq = 0; obsUnstable = 0; obsDone = 0;
      obsWe = 0; obsAddr = 0; obsWdata = 0; obsBe = 0;
      MemReadM = v.rd; MemWriteM = v.wr; Funct3M = v.f3;
      ALUResultM = v.addr; WriteDataM = v.wdata;
      for (int cyc = 0; cyc < 40 && !obsDone; cyc++) begin
         bus_req_ready = 1'b0;
         bus_rsp_valid = 1'b0;
         bus_rsp_rdata = v.rdata;
         if (bus_req_valid) begin
            if (!obsReq) begin
               obsReq = 1; obsWe = bus_req_we; obsAddr = bus_req_addr;
               obsWdata = bus_req_wdata; obsBe = bus_req_be;
            end else if (bus_req_we !== obsWe || bus_req_addr !== obsAddr ||
                         bus_req_wdata !== obsWdata || bus_req_be !== obsBe) begin
               obsUnstable = 1;
            end
            bus_req_ready = (reqSeen >= v.rdyDly);
            if (bus_req_ready && v.hsRsp) begin
               bus_rsp_valid = 1'b1;
               bus_rsp_rdata = 32'h1111_1111;
            end
            reqSeen++;
         end
         if (inRsp) begin
            bus_rsp_valid = (rspSeen >= v.rspDly);
            rspSeen++;
         end
         #1;
         if (!StallM) begin
            obsDone = 1; obsRdata = ReadDataM; obsMis = MisalignM; obsErr = BusErrM;
            obsValidAtDone = bus_req_valid;
         end else begin
            obsStall++;
         end
         inRspNext = inRsp | (bus_req_valid & bus_req_ready & ~bus_req_we);
         @(posedge clk); #1;
         inRsp = inRspNext;
      end
      bus_req_ready = 1'b0;
      bus_rsp_valid = 1'b0;
      obsMisAfter = MisalignM;
      obsErrAfter = BusErrM;
      MemReadM = 1'b0;
      MemWriteM = 1'b0;
   endtask

   task automatic runVector(input vec_t v);
      applyStimulus(v);
      checkOutput({v.name, "_done"}, 32'(obsDone), 32'd1);
      checkOutput({v.name, "_stall"}, 32'(obsStall), 32'(v.expStall));
      checkOutput({v.name, "_req"}, 32'(obsReq), 32'(v.expReq));
      checkOutput({v.name, "_rdata"}, obsRdata, v.expRdata);
      checkOutput({v.name, "_mis"}, 32'(obsMis), 32'(v.expMis));
      checkOutput({v.name, "_err"}, 32'(obsErr), 32'(v.expErr));
      checkOutput({v.name, "_valid_done"}, 32'(obsValidAtDone), 32'd0);
      checkOutput({v.name, "_mis_after"}, 32'(obsMisAfter), 32'd0);
      checkOutput({v.name, "_err_after"}, 32'(obsErrAfter), 32'd0);
      if (v.expReq) begin
         checkOutput({v.name, "_we"}, 32'(obsWe), 32'(v.wr & ~v.rd));
         checkOutput({v.name, "_addr"}, obsAddr, {v.addr[31:2], 2'b00});
         checkOutput({v.name, "_stable"}, 32'(obsUnstable), 32'd0);
         if (v.chkBe) checkOutput({v.name, "_be"}, 32'(obsBe), 32'(v.expBe));
         if (v.wr && !v.rd) checkOutput({v.name, "_wdata"}, obsWdata, v.expWdata);
      end
   endtask

   // Watchdog so the run always ends even if the DUT wedges the bench.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got simulation still running, expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      vec_t vecs[21];
      vecs[0]  = mk("lw_100",      1,0,3'b010,32'h100,32'h0,       32'hDEADBEEF,2,0,0, 5,1,1,4'b1111,32'h0,        32'hDEADBEEF,0,0);
      vecs[1]  = mk("sb_203",      0,1,3'b000,32'h203,32'h000000A5,32'h0,       0,0,0, 2,1,1,4'b1000,32'hA5A5A5A5, 32'hDEADBEEF,0,0);
      vecs[2]  = mk("lh_302",      1,0,3'b001,32'h302,32'h0,       32'h80017FFF,0,0,0, 3,1,0,4'b0000,32'h0,        32'hFFFF8001,0,0);
      vecs[3]  = mk("lhu_302",     1,0,3'b101,32'h302,32'h0,       32'h80017FFF,0,0,0, 3,1,0,4'b0000,32'h0,        32'h00008001,0,0);
      vecs[4]  = mk("lb_301",      1,0,3'b000,32'h301,32'h0,       32'h000080FF,0,0,0, 3,1,0,4'b0000,32'h0,        32'hFFFFFF80,0,0);
      vecs[5]  = mk("lbu_300",     1,0,3'b100,32'h300,32'h0,       32'h000080FF,0,0,0, 3,1,0,4'b0000,32'h0,        32'h000000FF,0,0);
      vecs[6]  = mk("sh_206",      0,1,3'b001,32'h206,32'h1234BEEF,32'h0,       0,0,0, 2,1,1,4'b1100,32'hBEEFBEEF, 32'h000000FF,0,0);
      vecs[7]  = mk("sh_204",      0,1,3'b001,32'h204,32'h0000CAFE,32'h0,       0,0,0, 2,1,1,4'b0011,32'hCAFECAFE, 32'h000000FF,0,0);
      vecs[8]  = mk("sw_208",      0,1,3'b010,32'h208,32'h01234567,32'h0,       0,0,0, 2,1,1,4'b1111,32'h01234567, 32'h000000FF,0,0);
      vecs[9]  = mk("lb_107_slow", 1,0,3'b000,32'h107,32'h0,       32'h7F000000,1,2,0, 6,1,0,4'b0000,32'h0,        32'h0000007F,0,0);
      vecs[10] = mk("lw_102_mis",  1,0,3'b010,32'h102,32'h0,       32'h0,       0,0,0, 1,0,0,4'b0000,32'h0,        32'h00000000,1,0);
      vecs[11] = mk("lbu_102",     1,0,3'b100,32'h102,32'h0,       32'h00AB0000,0,0,0, 3,1,0,4'b0000,32'h0,        32'h000000AB,0,0);
      vecs[12] = mk("sh_201_mis",  0,1,3'b001,32'h201,32'h0000BEEF,32'h0,       0,0,0, 1,0,0,4'b0000,32'h0,        32'h00000000,1,0);
      vecs[13] = mk("rd_wr_both",  1,1,3'b010,32'h040,32'hFFFFFFFF,32'h55AA55AA,0,0,0, 3,1,1,4'b1111,32'h0,        32'h55AA55AA,0,0);
      vecs[14] = mk("f3_111_word", 1,0,3'b111,32'h044,32'h0,       32'h89ABCDEF,0,0,0, 3,1,1,4'b1111,32'h0,        32'h89ABCDEF,0,0);
      vecs[15] = mk("f3_110_mis",  1,0,3'b110,32'h045,32'h0,       32'h0,       0,0,0, 1,0,0,4'b0000,32'h0,        32'h00000000,1,0);
      vecs[16] = mk("lhu_030",     1,0,3'b101,32'h030,32'h0,       32'hFFFF1234,0,0,0, 3,1,0,4'b0000,32'h0,        32'h00001234,0,0);
      vecs[17] = mk("lw_rsp_tmo",  1,0,3'b010,32'h050,32'h0,       32'h0BADBEEF,0,99,0,6,1,1,4'b1111,32'h0,        32'h00000000,0,1);
      vecs[18] = mk("lw_054",      1,0,3'b010,32'h054,32'h0,       32'h12345678,0,0,0, 3,1,1,4'b1111,32'h0,        32'h12345678,0,0);
      vecs[19] = mk("sw_req_tmo",  0,1,3'b010,32'h060,32'h0BADF00D,32'h0,       99,0,0,5,1,1,4'b1111,32'h0BADF00D, 32'h00000000,0,1);
      vecs[20] = mk("lw_hs_rsp",   1,0,3'b010,32'h070,32'h0,       32'hCAFEF00D,0,1,1, 4,1,1,4'b1111,32'h0,        32'hCAFEF00D,0,0);

      reset = 1'b0;
      MemReadM = 1'b1; MemWriteM = 1'b0; Funct3M = 3'b010;
      ALUResultM = 32'h100; WriteDataM = 32'h0;
      bus_req_ready = 1'b0; bus_rsp_valid = 1'b0; bus_rsp_rdata = 32'h0;

      // Reset held with an access pending: everything quiet, no stall.
      #3;
      checkOutput("reset_stall", 32'(StallM), 32'd0);
      checkOutput("reset_valid", 32'(bus_req_valid), 32'd0);
      checkOutput("reset_rdata", ReadDataM, 32'h0);
      checkOutput("reset_mis", 32'(MisalignM), 32'd0);
      checkOutput("reset_err", 32'(BusErrM), 32'd0);
      checkOutput("reset_be", 32'(bus_req_be), 32'd0);
      checkOutput("reset_addr", bus_req_addr, 32'h0);
      MemReadM = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;

      $display("[TB] running %0d table vectors", 21);
      for (int i = 0; i < 21; i++) runVector(vecs[i]);

      // Asynchronous reset while waiting for a read response.
      $display("[TB] reset during RSP");
      MemReadM = 1'b1; Funct3M = 3'b010; ALUResultM = 32'h80;
      @(posedge clk); #1;
      checkOutput("rstseq_in_req", 32'(bus_req_valid), 32'd1);
      bus_req_ready = 1'b1;
      @(posedge clk); #1;
      bus_req_ready = 1'b0;
      checkOutput("rstseq_rsp_stall", 32'(StallM), 32'd1);
      checkOutput("rstseq_rsp_hold", ReadDataM, 32'hCAFEF00D);
      #2;
      reset = 1'b0;
      #1;
      checkOutput("rstseq_valid", 32'(bus_req_valid), 32'd0);
      checkOutput("rstseq_stall", 32'(StallM), 32'd0);
      checkOutput("rstseq_rdata", ReadDataM, 32'h0);
      checkOutput("rstseq_addr", bus_req_addr, 32'h0);
      checkOutput("rstseq_be", 32'(bus_req_be), 32'd0);
      MemReadM = 1'b0;
      @(posedge clk); #1;
      reset = 1'b1;

      // A stray response after reset must not wake the unit.
      bus_rsp_valid = 1'b1;
      bus_rsp_rdata = 32'hFFFF_FFFF;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         checkOutput($sformatf("late_rsp_stall_%0d", i), 32'(StallM), 32'd0);
         checkOutput($sformatf("late_rsp_valid_%0d", i), 32'(bus_req_valid), 32'd0);
         checkOutput($sformatf("late_rsp_rdata_%0d", i), ReadDataM, 32'h0);
      end
      bus_rsp_valid = 1'b0;

      runVector(mk("lw_after_rst", 1,0,3'b010,32'h090,32'h0,32'h13579BDF,0,0,0, 3,1,1,4'b1111,32'h0, 32'h13579BDF,0,0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
Memory-stage load/store unit. It sits directly downstream of the datapath's execute/memory pipeline register. It consumes ALUResultM (address), WriteDataM and the memory controls, and drives a valid/ready data bus. It returns a sign- or zero-extended ReadDataM to the memory/writeback register and raises StallM to the hazard unit while an access is outstanding.

Parameters:
TIMEOUT, 255, number of cycles spent in REQ or RSP before the access is aborted with a bus error.
CNT_W, 8, width of the timeout counter; TIMEOUT must be less than 2**CNT_W.

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
MemReadM  in  1  load in the M stage
MemWriteM  in  1  store in the M stage
Funct3M  in  3  access size/sign: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU
ALUResultM  in  32  byte address
WriteDataM  in  32  store data, right-aligned
ReadDataM  out  32  extended load data, registered
StallM  out  1  stall request to the hazard unit (freezes F/D/E/M)
MisalignM  out  1  one-cycle pulse: misaligned access, no bus request issued
BusErrM  out  1  one-cycle pulse: timeout abort
bus_req_valid  out  1  request valid
bus_req_ready  in  1  request accepted
bus_req_we  out  1  1 = write
bus_req_addr  out  32  {addr[31:2],2'b00}
bus_req_wdata  out  32  lane-replicated store data
bus_req_be  out  4  byte enables
bus_rsp_valid  in  1  read response valid (writes get no response)
bus_rsp_rdata  in  32  read word

Behaviour:
- Reset (reset=0, async): state=IDLE; ReadDataM=0; bus_req_* all 0; MisalignM, BusErrM, StallM = 0; timeout counter = 0. Reset mid-access aborts immediately; bus_req_valid drops without a handshake.
- access = MemReadM | MemWriteM. If both are set, the read wins and the write is ignored.
- StallM = (state != DONE) & (state != IDLE | access). It is combinational and is 0 while in reset.
- FSM states: IDLE, REQ, RSP, DONE.
- IDLE, access, aligned: register we, address, wdata and be onto the bus outputs; go to REQ.
- IDLE, access, misaligned: pulse MisalignM next cycle, set ReadDataM=0, go to DONE. Misaligned means a halfword with addr[0]=1, or a word with addr[1:0]!=0.
- REQ: bus_req_valid=1, with all request fields held stable until bus_req_ready=1.
  - On handshake: a write goes to DONE; a read goes to RSP.
- RSP: on bus_rsp_valid, load the extended data into ReadDataM and go to DONE. A response arriving in the handshake cycle itself is ignored; a response in any cycle while in RSP is accepted.
- DONE: StallM=0 for exactly one cycle so the pipeline advances and the W register samples ReadDataM. Then go to IDLE, which re-evaluates the next M-stage instruction.
- Minimum access latency: load = 3 stall cycles (IDLE, REQ with ready=1, RSP with rsp_valid=1); store = 2.
- Timeout: the counter clears on entry to REQ and to RSP and increments each cycle in those states. On reaching TIMEOUT it pulses BusErrM, sets ReadDataM=0, deasserts bus_req_valid and goes to DONE.
- Store lanes (a = addr[1:0]):
  - SB: be=1<<a, wdata={4{WriteDataM[7:0]}}
  - SH: be=a[1]?1100:0011, wdata={2{WriteDataM[15:0]}}
  - SW: be=1111
- Load extraction:
  - Byte = rdata[8a+7:8a], sign-extended for LB, zero-extended for LBU.
  - Halfword = rdata[16a[1]+15:16a[1]], sign-extended for LH, zero-extended for LHU.
  - LW passes the word through.
- Unlisted Funct3M codes are treated as word accesses.
- ReadDataM holds its value in all states except when it is written as above.
- MisalignM and BusErrM are registered and high for exactly the one DONE cycle.

Test Plan:
- LW 0x100; bus_req_ready after 2 cycles; rdata=0xDEADBEEF one cycle later -> bus_req_addr=0x100, be=1111; ReadDataM=0xDEADBEEF in the DONE cycle; StallM high for 5 cycles, then low for 1.
- SB 0x203, WriteDataM=0x000000A5, ready=1 -> be=1000, wdata=0xA5A5A5A5, addr=0x200, we=1; StallM high for 2 cycles; no response awaited.
- LH 0x302 with rdata=0x80017FFF -> ReadDataM=0xFFFF8001. LHU at the same address -> 0x00008001. LB 0x301 with rdata=0x000080FF -> 0xFFFFFF80.
- LW 0x102 -> bus_req_valid never asserts; MisalignM=1 and ReadDataM=0 in the DONE cycle; StallM high for 1 cycle.
- LW with bus_rsp_valid never asserted, TIMEOUT=4 -> BusErrM pulses 4 cycles after entering RSP; ReadDataM=0; the FSM returns to IDLE.
- Reset driven low while in RSP -> bus_req_valid, StallM and ReadDataM go to 0 asynchronously. After release with no access, the FSM stays in IDLE and a late bus_rsp_valid is ignored.
